// File: rtl/fpga_clock_divider.sv
// Single-domain clock front end: free-running divider counter, selectable
// divided square wave with a matching enable strobe, registered switches and lock emulation.
module fpga_clock_divider #(
  parameter int SWITCH_CLOCK   = 0,
  parameter int FIXED_DIV_LOG2 = 1,
  parameter int LOCK_CYCLES    = 16
) (
  input  logic        sysclk,
  input  logic        dcm_reset,
  input  logic [7:0]  slideswitch,
  output logic [7:0]  switches,
  output logic [22:0] slow,
  output logic        clk_div,
  output logic        clk_en,
  output logic        locked,
  output logic        pixclk
);

  localparam logic [15:0] LockLast = 16'(LOCK_CYCLES - 1);

  logic [7:0]  switches_q, switches_d;
  logic [22:0] slow_q, slow_d;
  logic [15:0] lock_cnt_q, lock_cnt_d;
  logic        locked_q, locked_d;

  logic        full_rate;
  logic [3:0]  div_k;
  logic [22:0] low_mask;
  logic        div_bit;

  always_ff @(posedge sysclk) begin
    if (dcm_reset) begin
      switches_q <= '0;
      slow_q     <= '0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      switches_q <= switches_d;
      slow_q     <= slow_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  // The lock counter freezes once locked; only a reset restarts the delay.
  always_comb begin
    switches_d = slideswitch;
    slow_d     = slow_q + 23'd1;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (!locked_q) begin
      lock_cnt_d = lock_cnt_q + 16'd1;
      if (lock_cnt_q == LockLast) begin
        locked_d = 1'b1;
      end
    end
  end

  // Highest set switch wins; switches[7] plays no part in the selection.
  always_comb begin
    full_rate = 1'b0;
    div_k     = 4'd0;
    if (SWITCH_CLOCK != 0) begin
      if (switches_q[6])      div_k = 4'd10;
      else if (switches_q[5]) div_k = 4'd8;
      else if (switches_q[4]) div_k = 4'd4;
      else if (switches_q[3]) div_k = 4'd3;
      else if (switches_q[2]) div_k = 4'd2;
      else if (switches_q[1]) div_k = 4'd1;
      else if (switches_q[0]) div_k = 4'd0;
      else                    full_rate = 1'b1;
    end else if (FIXED_DIV_LOG2 == 0) begin
      full_rate = 1'b1;
    end else begin
      div_k = 4'(FIXED_DIV_LOG2 - 1);
    end
  end

  assign low_mask = (23'd1 << div_k) - 23'd1;
  assign div_bit  = slow_q[div_k];

  assign switches = switches_q;
  assign slow     = slow_q;
  assign locked   = locked_q;
  assign clk_div  = full_rate ? slow_q[0] : div_bit;
  assign clk_en   = locked_q & (full_rate | (div_bit & ((slow_q & low_mask) == 23'd0)));
  assign pixclk   = 1'b0;

endmodule

// File: tb/tb_fpga_clock_divider.sv
// Directed bench for fpga_clock_divider: default fixed ÷2, fixed ÷8 and
// switch-selected instances share clock, reset and switches.
module tb_fpga_clock_divider;

  logic        sysclk = 1'b0;
  logic        dcm_reset;
  logic [7:0]  slideswitch;

  logic [7:0]  sw0, sw1, sw2;
  logic [22:0] slow0, slow1, slow2;
  logic        div0, div1, div2;
  logic        en0, en1, en2;
  logic        lock0, lock1, lock2;
  logic        pix0, pix1, pix2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 sysclk = ~sysclk;

  fpga_clock_divider dut0 (
    .sysclk(sysclk), .dcm_reset(dcm_reset), .slideswitch(slideswitch),
    .switches(sw0), .slow(slow0), .clk_div(div0), .clk_en(en0),
    .locked(lock0), .pixclk(pix0)
  );

  fpga_clock_divider #(.SWITCH_CLOCK(1), .FIXED_DIV_LOG2(1), .LOCK_CYCLES(16)) dut1 (
    .sysclk(sysclk), .dcm_reset(dcm_reset), .slideswitch(slideswitch),
    .switches(sw1), .slow(slow1), .clk_div(div1), .clk_en(en1),
    .locked(lock1), .pixclk(pix1)
  );

  fpga_clock_divider #(.SWITCH_CLOCK(0), .FIXED_DIV_LOG2(3), .LOCK_CYCLES(16)) dut2 (
    .sysclk(sysclk), .dcm_reset(dcm_reset), .slideswitch(slideswitch),
    .switches(sw2), .slow(slow2), .clk_div(div2), .clk_en(en2),
    .locked(lock2), .pixclk(pix2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] sw);
    slideswitch = sw;
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
    cyc++;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " sw0"},   32'(sw0),   32'd0);
    checkOutput({tag, " sw1"},   32'(sw1),   32'd0);
    checkOutput({tag, " sw2"},   32'(sw2),   32'd0);
    checkOutput({tag, " slow0"}, 32'(slow0), 32'd0);
    checkOutput({tag, " slow1"}, 32'(slow1), 32'd0);
    checkOutput({tag, " slow2"}, 32'(slow2), 32'd0);
    checkOutput({tag, " lock0"}, 32'(lock0), 32'd0);
    checkOutput({tag, " lock1"}, 32'(lock1), 32'd0);
    checkOutput({tag, " lock2"}, 32'(lock2), 32'd0);
    checkOutput({tag, " en0"},   32'(en0),   32'd0);
    checkOutput({tag, " en1"},   32'(en1),   32'd0);
    checkOutput({tag, " en2"},   32'(en2),   32'd0);
    checkOutput({tag, " div0"},  32'(div0),  32'd0);
    checkOutput({tag, " div1"},  32'(div1),  32'd0);
    checkOutput({tag, " div2"},  32'(div2),  32'd0);
  endtask

  // Lock window after a reset release: cycle c has slow=c and locked from c=16.
  task automatic checkLockWindow(input string tag);
    logic [31:0] c;
    logic        isLocked;
    for (int i = 0; i < 40; i++) begin
      c        = 32'(cyc);
      isLocked = (cyc >= 16);
      checkOutput({tag, " slow0"}, 32'(slow0), c);
      checkOutput({tag, " lock0"}, 32'(lock0), 32'(isLocked));
      checkOutput({tag, " lock1"}, 32'(lock1), 32'(isLocked));
      checkOutput({tag, " lock2"}, 32'(lock2), 32'(isLocked));
      checkOutput({tag, " div0"},  32'(div0),  32'(c[0]));
      checkOutput({tag, " en0"},   32'(en0),   32'(isLocked && c[0]));
      checkOutput({tag, " div2"},  32'(div2),  32'(c[2]));
      checkOutput({tag, " en2"},   32'(en2),   32'(isLocked && (c[2:0] == 3'b100)));
      checkOutput({tag, " en1"},   32'(en1),   32'(isLocked));
      checkOutput({tag, " pix"},   32'({pix0, pix1, pix2}), 32'd0);
      step();
    end
  endtask

  logic [7:0]  patSw [9] = '{8'h10, 8'h41, 8'h04, 8'h08, 8'h02, 8'h01, 8'h20, 8'h80, 8'h00};
  int          patK  [9] = '{4, 10, 2, 3, 1, 0, 8, -1, -1};

  initial begin
    logic [31:0] c;
    logic [31:0] mask;
    logic [22:0] w;
    logic        expEn;
    logic        expDiv;
    int          span;
    int          pulses;

    applyStimulus(8'h00);
    dcm_reset = 1'b1;
    step(); step(); step();
    checkAllZero("reset");
    checkOutput("reset pix", 32'({pix0, pix1, pix2}), 32'd0);

    dcm_reset = 1'b0;
    cyc = 0;
    checkLockWindow("lock");

    // Each pattern: one edge to register, one more to settle, then two full periods.
    for (int p = 0; p < 9; p++) begin
      applyStimulus(patSw[p]);
      step();
      checkOutput("switches", 32'(sw1), 32'(patSw[p]));
      step();
      span   = (patK[p] < 0) ? 8 : (4 << patK[p]);
      pulses = 0;
      for (int i = 0; i < span; i++) begin
        c = 32'(cyc);
        if (patK[p] < 0) begin
          expDiv = c[0];
          expEn  = 1'b1;
        end else begin
          mask   = (32'd1 << patK[p]) - 32'd1;
          expDiv = c[patK[p]];
          expEn  = expDiv && ((c & mask) == 32'd0);
        end
        checkOutput("sel slow", 32'(slow1), c);
        checkOutput("sel div",  32'(div1),  32'(expDiv));
        checkOutput("sel en",   32'(en1),   32'(expEn));
        if (en1) pulses++;
        step();
      end
      checkOutput("sel pulses", 32'(pulses), 32'((patK[p] < 0) ? span : 2));
    end

    // Preload dut0 just below the wrap point and watch it roll over.
    force dut0.slow_q = 23'h7FFFFD;
    #1;
    release dut0.slow_q;
    w = 23'h7FFFFD;
    for (int i = 0; i < 8; i++) begin
      checkOutput("wrap slow", 32'(slow0), 32'(w));
      checkOutput("wrap en",   32'(en0),   32'(w[0]));
      checkOutput("wrap div",  32'(div0),  32'(w[0]));
      step();
      w = w + 23'd1;
    end

    dcm_reset = 1'b1;
    step();
    checkAllZero("midreset");
    dcm_reset = 1'b0;
    cyc = 0;
    checkLockWindow("relock");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
